lcd_pixel_sink: RTL

//  Receive end of the LCD pixel-stream interface: samples the red/green/blue/hsync/vsync/de

---
 rtl/lcd_pkg.sv | 20 ++
 rtl/lcd_sync_edge.sv | 54 +++++
 rtl/lcd_pixel_sink.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types and geometry defaults for the LCD pixel-stream receive path.
package lcd_pkg;

    localparam int H_ACTIVE_DEF = 800;
    localparam int V_ACTIVE_DEF = 480;
    localparam int X_W          = 11;
    localparam int Y_W          = 10;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic {
        HUNT  = 1'b0,
        FRAME = 1'b1
    } sink_state_e;

endpackage

// File: rtl/lcd_sync_edge.sv
// Input stage: registers the qualified pixel bundle, normalises sync polarity
// and derives DE / vsync edges between consecutive qualified samples.
module lcd_sync_edge
    import lcd_pkg::*;
#(
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    input  logic       vsync,
    input  logic       de,
    input  logic       dclk_en,
    output logic       q_valid,
    output rgb_t       rgb,
    output logic       de_cur,
    output logic       de_rise,
    output logic       vs_rise
);

    logic de_q;
    logic de_p;
    logic vs_q;
    logic vs_p;

    // q_valid marks that the current/previous copies advanced this cycle,
    // so downstream logic acts exactly once per qualified sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            rgb     <= '0;
            de_q    <= 1'b0;
            de_p    <= 1'b0;
            vs_q    <= 1'b0;
            vs_p    <= 1'b0;
        end else begin
            q_valid <= dclk_en;
            if (dclk_en) begin
                rgb  <= rgb_t'({red, green, blue});
                de_q <= de;
                de_p <= de_q;
                vs_q <= vsync ^ SYNC_ACTIVE_LOW;
                vs_p <= vs_q;
            end
        end
    end

    assign de_cur  = de_q;
    assign de_rise = de_q & ~de_p;
    assign vs_rise = vs_q & ~vs_p;

endmodule

// File: rtl/lcd_pixel_sink.sv
// LCD pixel-stream sink: recovers pixel coordinates, line/frame markers,
// geometry errors and a lock indication from the DE/vsync bundle.
module lcd_pixel_sink
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE        = H_ACTIVE_DEF,
    parameter int V_ACTIVE        = V_ACTIVE_DEF,
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int LOCK_FRAMES     = 2
) (
    input  logic            clk_clk,
    input  logic            reset_reset_n,
    input  logic [7:0]      lcd_red,
    input  logic [7:0]      lcd_green,
    input  logic [7:0]      lcd_blue,
    input  logic            lcd_hsync,
    input  logic            lcd_vsync,
    input  logic            lcd_de,
    input  logic            lcd_dclk_en,
    output logic            pix_valid,
    output logic [X_W-1:0]  pix_x,
    output logic [Y_W-1:0]  pix_y,
    output logic [23:0]     pix_rgb,
    output logic            sof,
    output logic            eol,
    output logic            frame_done,
    output logic            err_width,
    output logic            err_height,
    output logic            locked
);

    localparam int             LW     = $clog2(LOCK_FRAMES + 1);
    localparam logic [X_W-1:0] H_EXP  = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0] V_EXP  = Y_W'(V_ACTIVE);
    localparam logic [LW-1:0]  LOCK_C = LW'(LOCK_FRAMES);

    logic q_valid;
    rgb_t rgb;
    logic de_cur;
    logic de_rise;
    logic vs_rise;

    // hsync carries no information the counters need; DE alone frames a line.
    logic unused_hsync;
    assign unused_hsync = lcd_hsync;

    lcd_sync_edge #(.SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_sync_edge (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .red     (lcd_red),
        .green   (lcd_green),
        .blue    (lcd_blue),
        .vsync   (lcd_vsync),
        .de      (lcd_de),
        .dclk_en (lcd_dclk_en),
        .q_valid (q_valid),
        .rgb     (rgb),
        .de_cur  (de_cur),
        .de_rise (de_rise),
        .vs_rise (vs_rise)
    );

    sink_state_e    state_q, state_d;
    logic [X_W-1:0] x_q, x_d, x_cur;
    logic [Y_W-1:0] y_q, y_d;
    logic           in_line_q, in_line_d;
    logic           frame_err_q, frame_err_d;
    logic [LW-1:0]  clean_q, clean_d;
    logic           pv_d, sof_d, eol_d, fd_d, ew_d, eh_d, locked_d;
    logic [X_W-1:0] px_d;
    logic [Y_W-1:0] py_d;
    logic [23:0]    prgb_d;

    // A vsync edge landing on an open line closes that line first (no pixel is
    // taken from that sample), then closes the frame on the updated line count.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        in_line_d   = in_line_q;
        frame_err_d = frame_err_q;
        clean_d     = clean_q;
        locked_d    = locked;
        pv_d        = 1'b0;
        sof_d       = 1'b0;
        eol_d       = 1'b0;
        fd_d        = 1'b0;
        ew_d        = 1'b0;
        eh_d        = 1'b0;
        px_d        = pix_x;
        py_d        = pix_y;
        prgb_d      = pix_rgb;
        x_cur       = in_line_q ? x_q : '0;
        if (q_valid) begin
            case (state_q)
                HUNT: begin
                    if (vs_rise) begin
                        state_d     = FRAME;
                        x_d         = '0;
                        y_d         = '0;
                        in_line_d   = 1'b0;
                        frame_err_d = 1'b0;
                    end
                end
                FRAME: begin
                    if (in_line_q && (!de_cur || vs_rise)) begin
                        eol_d     = 1'b1;
                        ew_d      = (x_q != H_EXP);
                        y_d       = (y_q == '1) ? y_q : y_q + 1'b1;
                        x_d       = '0;
                        in_line_d = 1'b0;
                    end else if (de_cur && !vs_rise && (in_line_q || de_rise)) begin
                        pv_d      = 1'b1;
                        px_d      = x_cur;
                        py_d      = y_q;
                        prgb_d    = rgb;
                        sof_d     = (x_cur == '0) && (y_q == '0);
                        x_d       = (x_cur == '1) ? x_cur : x_cur + 1'b1;
                        in_line_d = 1'b1;
                    end
                    if (vs_rise) begin
                        fd_d = 1'b1;
                        eh_d = (y_d != V_EXP);
                        y_d  = '0;
                        x_d  = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
            if (ew_d) begin
                frame_err_d = 1'b1;
            end
            if (fd_d) begin
                if (eh_d || frame_err_d) begin
                    clean_d = '0;
                end else if (clean_q < LOCK_C) begin
                    clean_d = clean_q + 1'b1;
                end
                frame_err_d = 1'b0;
            end else if (ew_d) begin
                clean_d = '0;
            end
            locked_d = (clean_d == LOCK_C);
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= HUNT;
            x_q         <= '0;
            y_q         <= '0;
            in_line_q   <= 1'b0;
            frame_err_q <= 1'b0;
            clean_q     <= '0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
            sof         <= 1'b0;
            eol         <= 1'b0;
            frame_done  <= 1'b0;
            err_width   <= 1'b0;
            err_height  <= 1'b0;
            locked      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            in_line_q   <= in_line_d;
            frame_err_q <= frame_err_d;
            clean_q     <= clean_d;
            pix_valid   <= pv_d;
            pix_x       <= px_d;
            pix_y       <= py_d;
            pix_rgb     <= prgb_d;
            sof         <= sof_d;
            eol         <= eol_d;
            frame_done  <= fd_d;
            err_width   <= ew_d;
            err_height  <= eh_d;
            locked      <= locked_d;
        end
    end

endmodule
